// File: rtl/axi_wr_burst_arb_if.sv
// axi_wr_burst_arb_if: request, grant, downstream handshake and status bundle of the AXI write burst arbiter
//   master: drives req, aw_fire, w_fire, w_last, b_fire; observes grant, grant_valid, grant_sel, w_sel, w_sel_valid, outstanding, busy
//   slave : the arbiter side of the same signals
interface axi_wr_burst_arb_if #(
  parameter int PORTS = 4,
  parameter int ISSUE = 4,
  parameter int SEL_WIDTH = $clog2(PORTS)
);
  localparam int CW = $clog2(ISSUE + 1);
  logic [PORTS-1:0] req;
  logic [PORTS-1:0] grant;
  logic grant_valid;
  logic [SEL_WIDTH-1:0] grant_sel;
  logic aw_fire;
  logic w_fire;
  logic w_last;
  logic b_fire;
  logic [SEL_WIDTH-1:0] w_sel;
  logic w_sel_valid;
  logic [CW-1:0] outstanding;
  logic busy;
  modport master (
    output req, aw_fire, w_fire, w_last, b_fire,
    input grant, grant_valid, grant_sel, w_sel, w_sel_valid, outstanding, busy
  );
  modport slave (
    input req, aw_fire, w_fire, w_last, b_fire,
    output grant, grant_valid, grant_sel, w_sel, w_sel_valid, outstanding, busy
  );
endinterface

// File: rtl/axi_wr_burst_arb.sv
// axi_wr_burst_arb: round-robin AW arbiter with W-path steering and outstanding-write limit
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave modport carrying req/grant/grant_valid/grant_sel, aw/w/b handshakes, w_sel/w_sel_valid, outstanding, busy
module axi_wr_burst_arb #(
  parameter int PORTS = 4,
  parameter int ISSUE = 4,
  parameter int SEL_WIDTH = $clog2(PORTS)
) (
  input logic clk,
  input logic rst,
  axi_wr_burst_arb_if.slave bus
);
  localparam int CW = $clog2(ISSUE + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  logic [1:0] state;
  logic [SEL_WIDTH-1:0] last_grant;
  logic [SEL_WIDTH-1:0] pick;
  logic found;
  logic load;
  logic inc;
  logic dec;
  int idx;
  // Round-robin search from last_grant+1, wrapping at PORTS.
  always_comb begin
    pick = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 1; i <= PORTS; i++) begin
      idx = (int'(last_grant) + i) % PORTS;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick = idx[SEL_WIDTH-1:0];
      end
    end
  end
  assign load = state == IDLE && found && bus.outstanding < CW'(ISSUE);
  assign inc = state == ADDR && bus.aw_fire;
  assign dec = bus.b_fire && bus.outstanding != '0;
  assign bus.grant_valid = |bus.grant;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= SEL_WIDTH'(PORTS - 1);
      bus.grant <= '0;
      bus.grant_sel <= '0;
      bus.w_sel <= '0;
      bus.w_sel_valid <= 1'b0;
      bus.outstanding <= '0;
    end else begin
      bus.outstanding <= bus.outstanding + CW'(inc) - CW'(dec);
      if (load) begin
        state <= ADDR;
        bus.grant <= PORTS'(1) << pick;
        bus.grant_sel <= pick;
        last_grant <= pick;
      end else if (inc) begin
        state <= DATA;
        bus.grant <= '0;
        bus.grant_sel <= '0;
        bus.w_sel <= bus.grant_sel;
        bus.w_sel_valid <= 1'b1;
      end else if (state == DATA && bus.w_fire && bus.w_last) begin
        state <= IDLE;
        bus.w_sel <= '0;
        bus.w_sel_valid <= 1'b0;
      end
    end
  end
endmodule
